// File: rtl/data_delay_pkg.sv
// data_delay_pkg: shared state encoding and width helpers for the data_delay_mc delay line
package data_delay_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_e;
  function automatic int dd_clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int dd_sum_w(input int bus_len, input int addr_w);
    return bus_len + addr_w + 1;
  endfunction
endpackage

// File: rtl/data_delay_ram.sv
// data_delay_ram: simple dual-port sample buffer, synchronous write, read-before-write
module data_delay_ram
  import data_delay_pkg::*;
#(
  parameter int W = 32,
  parameter int DEPTH = 32,
  localparam int AW = dd_clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;
  // Read sees the old entry when rd_addr == wr_addr in the same cycle
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/data_delay_mc.sv
// data_delay_mc: multi-channel runtime-programmable sample delay line with fill tracking.
// Define DATA_DELAY_MAVG_EN to build the per-channel windowed running sum on sum_out.
module data_delay_mc
  import data_delay_pkg::*;
#(
  parameter int BUS_LENGTH = 16,
  parameter int NUM_CH = 2,
  parameter int MAX_DELAY = 32,
  localparam int ADDR_W = dd_clog2(MAX_DELAY),
  localparam int SUM_W = dd_sum_w(BUS_LENGTH, ADDR_W)
) (
  input  logic                         clk_in,
  input  logic                         rst_n,
  input  logic [NUM_CH*BUS_LENGTH-1:0] data_in,
  input  logic                         data_valid_in,
  input  logic [ADDR_W:0]              delay_in,
  output logic [NUM_CH*BUS_LENGTH-1:0] data_out,
  output logic                         data_valid_out,
  output logic                         primed_out,
  output logic [NUM_CH*SUM_W-1:0]      sum_out
);
  localparam int W = NUM_CH * BUS_LENGTH;
  localparam logic [ADDR_W:0] DMAX = (ADDR_W + 1)'(MAX_DELAY);
  localparam logic [ADDR_W:0] DONE = (ADDR_W + 1)'(1);
  state_e state_q, state_d;
  logic [ADDR_W:0] delay_q, delay_d, fill_q, fill_d, d_req;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_addr;
  logic [W-1:0] data_q, data_d, rd_data;
  logic valid_q, primed_q, primed_d, chg;
  data_delay_ram #(.W(W), .DEPTH(MAX_DELAY)) u_ram (
    .clk(clk_in),
    .we(data_valid_in),
    .wr_addr(wr_ptr_q),
    .wr_data(data_in),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
  always_comb begin
    d_req = delay_in == '0 ? DONE : (delay_in > DMAX ? DMAX : delay_in);
    chg = data_valid_in && d_req != delay_q;
    rd_addr = wr_ptr_q - delay_q[ADDR_W-1:0];
    state_d = state_q;
    fill_d = fill_q;
    delay_d = delay_q;
    wr_ptr_d = wr_ptr_q;
    data_d = data_q;
    primed_d = primed_q;
    if (data_valid_in) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      delay_d = d_req;
      // A restart (delay change or first sample) counts as the first fill sample
      fill_d = (chg || state_q == IDLE) ? DONE : fill_q + (ADDR_W + 1)'(fill_q != d_req);
      primed_d = !chg && state_q == RUN;
      data_d = primed_d ? rd_data : '0;
      state_d = fill_d == d_req ? RUN : FILL;
    end
  end
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      fill_q <= '0;
      delay_q <= DONE;
      wr_ptr_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q <= fill_d;
      delay_q <= delay_d;
      wr_ptr_q <= wr_ptr_d;
      data_q <= data_d;
      valid_q <= data_valid_in;
      primed_q <= primed_d;
    end
  assign data_out = data_q;
  assign data_valid_out = valid_q;
  assign primed_out = primed_q;
`ifdef DATA_DELAY_MAVG_EN
  for (genvar c = 0; c < NUM_CH; c++) begin : g_acc
    logic signed [BUS_LENGTH-1:0] x, xd;
    logic signed [SUM_W-1:0] acc_q, acc_d, sub;
    always_comb begin
      x = data_in[c*BUS_LENGTH +: BUS_LENGTH];
      xd = rd_data[c*BUS_LENGTH +: BUS_LENGTH];
      sub = primed_d ? SUM_W'(xd) : SUM_W'(0);
      acc_d = !data_valid_in ? acc_q : (chg ? SUM_W'(x) : acc_q + SUM_W'(x) - sub);
    end
    always_ff @(posedge clk_in or negedge rst_n)
      if (!rst_n) acc_q <= '0;
      else acc_q <= acc_d;
    assign sum_out[c*SUM_W +: SUM_W] = acc_q;
  end
`else
  assign sum_out = '0;
`endif
endmodule

// File: tb/tb_data_delay_mc.sv
// tb_data_delay_mc: directed and randomized checks of data_delay_mc against a sample-history model
module tb_data_delay_mc;
  localparam int BL = 16, NC = 2, MD = 32, AW = 5, W = NC * BL, SW = BL + AW + 1;
  logic clk_in = 1'b0, rst_n = 1'b0;
  logic [W-1:0] data_in = '0;
  logic data_valid_in = 1'b0;
  logic [AW:0] delay_in = 6'd1;
  logic [W-1:0] data_out;
  logic data_valid_out, primed_out;
  logic [NC*SW-1:0] sum_out;
  int checks = 0, errors = 0;
  logic [W-1:0] hist[$];
  int es = 0, dcur = 1;
  bit started = 1'b0;
  logic [W-1:0] e_data = '0;
  logic e_valid = 1'b0, e_primed = 1'b0;
  logic [NC*SW-1:0] e_sum = '0;
  always #5 clk_in = ~clk_in;
  data_delay_mc dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .data_in(data_in),
    .data_valid_in(data_valid_in),
    .delay_in(delay_in),
    .data_out(data_out),
    .data_valid_out(data_valid_out),
    .primed_out(primed_out),
    .sum_out(sum_out)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    hist.delete();
    es = 0;
    dcur = 1;
    started = 1'b0;
    e_data = '0;
    e_valid = 1'b0;
    e_primed = 1'b0;
    e_sum = '0;
  endtask
  function automatic logic [W-1:0] ramp(input int n);
    logic [BL-1:0] a, b;
    a = BL'(n);
    b = BL'(-n);
    return {b, a};
  endfunction
  // The model: each accepted sample k outputs sample k-d once d samples of the current run exist
  task automatic step(input bit v, input logic [W-1:0] x, input int dl);
    int k, dr, s, lo;
    logic [W-1:0] h;
    logic signed [BL-1:0] v16;
    data_valid_in = v;
    data_in = x;
    delay_in = (AW + 1)'(dl);
    e_valid = v;
    if (v) begin
      k = hist.size();
      dr = dl == 0 ? 1 : (dl > MD ? MD : dl);
      if (!started || dr != dcur) begin
        es = k;
        dcur = dr;
        started = 1'b1;
      end
      hist.push_back(x);
      e_primed = (k - es) >= dcur;
      e_data = e_primed ? hist[k-dcur] : '0;
      lo = (k - dcur + 1 > es) ? k - dcur + 1 : es;
      for (int c = 0; c < NC; c++) begin
        s = 0;
        for (int j = lo; j <= k; j++) begin
          h = hist[j];
          v16 = h[c*BL +: BL];
          s += v16;
        end
`ifdef DATA_DELAY_MAVG_EN
        e_sum[c*SW +: SW] = SW'(s);
`else
        e_sum = '0;
`endif
      end
    end
    @(posedge clk_in);
    #2;
    chk("valid_out", 64'(data_valid_out), 64'(e_valid));
    chk("data_out", 64'(data_out), 64'(e_data));
    chk("primed_out", 64'(primed_out), 64'(e_primed));
    chk("sum_out", 64'(sum_out), 64'(e_sum));
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(data_valid_out), 64'd0);
    chk({tag, "_data"}, 64'(data_out), 64'd0);
    chk({tag, "_primed"}, 64'(primed_out), 64'd0);
    chk({tag, "_sum"}, 64'(sum_out), 64'd0);
  endtask
  initial begin
    int dl_r;
    #12;
    chk_zero("reset");
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int n = 1; n <= 40; n++) step(1'b1, ramp(n), 4);
    for (int n = 1; n <= 40; n++) step(1'b1, ramp(n), 32);
    for (int n = 1; n <= 15; n++) begin
      step(1'b1, W'($urandom), 3);
      step(1'b0, W'($urandom), 3);
      step(1'b0, W'($urandom), 3);
    end
    for (int n = 1; n <= 20; n++) step(1'b1, ramp(n), n < 10 ? 4 : 2);
    for (int n = 1; n <= 10; n++) step(1'b1, W'($urandom), 0);
    for (int n = 1; n <= 40; n++) step(1'b1, W'($urandom), 40);
    dl_r = 5;
    repeat (400) begin
      if ($urandom_range(0, 29) == 0) dl_r = $urandom_range(0, 40);
      step($urandom_range(0, 3) != 0, W'($urandom), dl_r);
    end
    for (int n = 1; n <= 10; n++) step(1'b1, ramp(n), 3);
    #1 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    model_reset();
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int n = 1; n <= 10; n++) step(1'b1, ramp(n + 100), 3);
    #1 rst_n = 1'b0;
    model_reset();
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int n = 1; n <= 6; n++) step(1'b1, ramp(n + 200), 1);
    for (int n = 1; n <= 8; n++) step(1'b1, {16'hFF9C, 16'hFF9C}, 4);
    for (int n = 1; n <= 6; n++) step(1'b1, {16'd50, 16'd50}, 4);
`ifdef DATA_DELAY_MAVG_EN
    chk("mavg_settle", 64'(sum_out), 64'({22'd200, 22'd200}));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
